// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the multiplier datapath blocks
package mult_pkg;

    typedef enum logic [1:0] {B2B_IDLE, B2B_CONVERT, B2B_DONE} b2b_state_t;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 8;

    // Largest magnitude a DIGITS-digit decimal entry can express.
    function automatic longint unsigned max_decimal(input int digits);
        longint unsigned v;
        v = 1;
        for (int i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// rtl/bcd_to_binary_if.sv - request/result bundle between keypad capture and the BCD decoder
interface bcd_to_binary_if #(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 16
);
    logic                  valid;
    logic [4*DIGITS-1:0]   BCD_code;
    logic                  sign;
    logic [OUT_W-1:0]      bin_result;
    logic                  bin_sign;
    logic                  busy;
    logic                  ready;
    logic                  digit_err;

    modport master (
        output valid, BCD_code, sign,
        input  bin_result, bin_sign, busy, ready, digit_err
    );

    modport slave (
        input  valid, BCD_code, sign,
        output bin_result, bin_sign, busy, ready, digit_err
    );
endinterface

// File: rtl/bcd_to_binary_digit_adjust.sv
// rtl/bcd_to_binary_digit_adjust.sv - one reverse double-dabble digit correction step
module bcd_digit_adjust
    import mult_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
            digit_o = digit_i - BCD_DIGIT_W'(3);
        end
    end
endmodule

// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - sequential BCD to two's-complement decoder (reverse double-dabble)
// Optional invalid-digit trap enabled by defining BCD_CHECK_EN.
module bcd_to_binary
    import mult_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    bcd_to_binary_if.slave   bus
);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BCD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCD_W - 1);

    if (max_decimal(DIGITS) >= (64'd1 << (OUT_W - 1))) begin : g_param_err
        $error("bcd_to_binary: OUT_W too narrow for DIGITS");
    end

    b2b_state_t        state_q, state_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [BCD_W-1:0]  bin_q, bin_d;
    logic              sign_q, sign_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  result_q, result_d;
    logic              bsign_q, bsign_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic [BCD_W-1:0]  shifted;
    logic [BCD_W-1:0]  adjusted;
    logic [OUT_W-1:0]  magnitude;
    logic              nonzero;

    assign shifted = {1'b0, bcd_q[BCD_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (shifted[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (adjusted[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    if (OUT_W > BCD_W) begin : g_ext
        assign magnitude = {{(OUT_W-BCD_W){1'b0}}, bin_q};
    end else if (OUT_W == BCD_W) begin : g_same
        assign magnitude = bin_q;
    end else begin : g_trunc
        assign magnitude = bin_q[OUT_W-1:0];
    end

    assign nonzero = |magnitude;

`ifdef BCD_CHECK_EN
    logic err_q, err_d;
    logic bad_digit;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.BCD_code[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign bus.digit_err = err_q;
`else
    assign bus.digit_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        bsign_d  = bsign_q;
        ready_d  = 1'b0;
        busy_d   = (state_q != B2B_IDLE);
`ifdef BCD_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            B2B_IDLE: begin
                if (bus.valid) begin
                    bcd_d   = bus.BCD_code;
                    bin_d   = '0;
                    sign_d  = bus.sign;
                    cnt_d   = '0;
                    state_d = B2B_CONVERT;
`ifdef BCD_CHECK_EN
                    err_d   = bad_digit;
                    if (bad_digit) begin
                        state_d = B2B_DONE;
                    end
`endif
                end
            end
            B2B_CONVERT: begin
                // Low BCD bit falls into the top of the binary accumulator.
                bcd_d = adjusted;
                bin_d = {bcd_q[0], bin_q[BCD_W-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = B2B_DONE;
                end
            end
            B2B_DONE: begin
                ready_d  = 1'b1;
                state_d  = B2B_IDLE;
                result_d = (sign_q && nonzero) ? (~magnitude + 1'b1) : magnitude;
                bsign_d  = sign_q & nonzero;
`ifdef BCD_CHECK_EN
                if (err_q) begin
                    result_d = '0;
                    bsign_d  = 1'b0;
                end
`endif
            end
            default: begin
                state_d = B2B_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= B2B_IDLE;
            bcd_q    <= '0;
            bin_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            bsign_q  <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef BCD_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            bsign_q  <= bsign_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
`ifdef BCD_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign bus.bin_result = result_q;
    assign bus.bin_sign   = bsign_q;
    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb/tb_bcd_to_binary.sv - directed vector bench for bcd_to_binary
module tb_bcd_to_binary;

    logic clk;
    logic reset;

    bcd_to_binary_if #(.DIGITS(4), .OUT_W(16)) bus ();

    bcd_to_binary #(.DIGITS(4), .OUT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    typedef struct {
        logic [15:0] code;
        logic        sgn;
        logic [15:0] exp_res;
        logic        exp_sgn;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Capture edge is edge 0; observes 24 further edges, optionally pulsing
    // valid with another code so that it is sampled at inject_edge.
    task automatic conv(input logic [15:0] code, input logic s,
                        input int inject_edge, input logic [15:0] inj_code,
                        output int first_ready, output int nready,
                        output logic [15:0] res, output logic rs, output logic de,
                        output logic [31:0] busy_hist);
        bus.BCD_code = code;
        bus.sign     = s;
        bus.valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.valid    = 1'b0;
        busy_hist    = '0;
        busy_hist[0] = bus.busy;
        first_ready  = -1;
        nready       = 0;
        res          = '0;
        rs           = 1'b0;
        de           = 1'b0;
        for (int e = 1; e <= 24; e++) begin
            if (e == inject_edge) begin
                bus.BCD_code = inj_code;
                bus.valid    = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.valid    = 1'b0;
            busy_hist[e] = bus.busy;
            if (bus.ready) begin
                nready++;
                if (first_ready < 0) begin
                    first_ready = e;
                    res = bus.bin_result;
                    rs  = bus.bin_sign;
                    de  = bus.digit_err;
                end
            end
        end
    endtask

    int          fr, nr, cnt_ready;
    logic [15:0] res;
    logic        rs, de;
    logic [31:0] bh;

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{16'h1234, 1'b0, 16'h04D2, 1'b0};
        vecs[1] = '{16'h9999, 1'b1, 16'hD8F1, 1'b1};
        vecs[2] = '{16'h0000, 1'b1, 16'h0000, 1'b0};
        vecs[3] = '{16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'h0001, 1'b0, 16'h0001, 1'b0};
        vecs[5] = '{16'h0042, 1'b1, 16'hFFD6, 1'b1};
        vecs[6] = '{16'h9999, 1'b0, 16'h270F, 1'b0};
        vecs[7] = '{16'h0100, 1'b0, 16'h0064, 1'b0};
        vecs[8] = '{16'h5000, 1'b1, 16'hEC78, 1'b1};
        vecs[9] = '{16'h0777, 1'b0, 16'h0309, 1'b0};

        reset        = 1'b1;
        bus.valid    = 1'b0;
        bus.BCD_code = '0;
        bus.sign     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", 32'(bus.bin_result), 32'h0);
        chk("reset_sign",   32'(bus.bin_sign),   32'h0);
        chk("reset_busy",   32'(bus.busy),       32'h0);
        chk("reset_ready",  32'(bus.ready),      32'h0);
        chk("reset_derr",   32'(bus.digit_err),  32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            conv(vecs[i].code, vecs[i].sgn, -1, 16'h0, fr, nr, res, rs, de, bh);
            chk($sformatf("v%0d_ready_edge", i), 32'(fr), 32'd17);
            chk($sformatf("v%0d_ready_count", i), 32'(nr), 32'd1);
            chk($sformatf("v%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
            chk($sformatf("v%0d_sign", i), 32'(rs), 32'(vecs[i].exp_sgn));
            chk($sformatf("v%0d_derr", i), 32'(de), 32'h0);
            if (i == 0) begin
                chk("busy_profile", bh & 32'h01FF_FFFF, 32'h0003_FFFE);
            end
        end

        // valid while busy is dropped, not queued
        conv(16'h0042, 1'b0, 5, 16'h0777, fr, nr, res, rs, de, bh);
        chk("midbusy_ready_count", 32'(nr), 32'd1);
        chk("midbusy_result", 32'(res), 32'h002A);
        conv(16'h0777, 1'b0, -1, 16'h0, fr, nr, res, rs, de, bh);
        chk("after_midbusy_result", 32'(res), 32'h0309);

        // valid sampled in the DONE cycle is dropped as well
        conv(16'h0012, 1'b0, 17, 16'h0034, fr, nr, res, rs, de, bh);
        chk("done_valid_ready_count", 32'(nr), 32'd1);
        chk("done_valid_result", 32'(res), 32'h000C);
        chk("done_valid_idle", 32'(bh[24:19]), 32'h0);

        // reset at edge 8 aborts the conversion
        bus.BCD_code = 16'h0555;
        bus.sign     = 1'b1;
        bus.valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_result", 32'(bus.bin_result), 32'h0);
        chk("abort_sign",   32'(bus.bin_sign),   32'h0);
        chk("abort_busy",   32'(bus.busy),       32'h0);
        chk("abort_ready",  32'(bus.ready),      32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cnt_ready = 0;
        for (int e = 0; e < 25; e++) begin
            @(posedge clk);
            #1;
            if (bus.ready) cnt_ready++;
        end
        chk("abort_no_ready", 32'(cnt_ready), 32'd0);
        conv(16'h0100, 1'b0, -1, 16'h0, fr, nr, res, rs, de, bh);
        chk("post_abort_edge", 32'(fr), 32'd17);
        chk("post_abort_result", 32'(res), 32'h0064);

`ifdef BCD_CHECK_EN
        conv(16'h12A4, 1'b0, -1, 16'h0, fr, nr, res, rs, de, bh);
        chk("bad_ready_edge", 32'(fr), 32'd1);
        chk("bad_ready_count", 32'(nr), 32'd1);
        chk("bad_derr", 32'(de), 32'h1);
        chk("bad_result", 32'(res), 32'h0);
        chk("bad_sign", 32'(rs), 32'h0);
        chk("bad_derr_hold", 32'(bus.digit_err), 32'h1);
        conv(16'h0005, 1'b0, -1, 16'h0, fr, nr, res, rs, de, bh);
        chk("good_ready_edge", 32'(fr), 32'd17);
        chk("good_derr", 32'(de), 32'h0);
        chk("good_result", 32'(res), 32'h0005);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
